// File: rtl/lfsr32_pkg.sv
// Shared definitions for the 32-bit PRBS generator/checker pair
// (polynomial x^32 + x^22 + x^2 + x + 1).
package lfsr32_pkg;

   localparam logic [31:0] LFSR32_RESET = 32'h0000_0001;

   typedef enum logic {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } chk_state_e;

   // One advance of the LFSR; the output bit of a state is always s[0].
   function automatic logic [31:0] lfsr32_step(input logic [31:0] s);
      logic [31:0] n;
      n[31]    = s[0];
      n[30:22] = s[31:23];
      n[21]    = s[0] ^ s[22];
      n[20:2]  = s[21:3];
      n[1]     = s[0] ^ s[2];
      n[0]     = s[0] ^ s[1];
      return n;
   endfunction

endpackage

// File: rtl/lfsr32_checker.sv
// Receive-side PRBS checker: slip-aligns a local LFSR replica to the serial
// stream, declares lock after a run of matches and counts errors while locked.
module lfsr32_checker
   import lfsr32_pkg::*;
#(
   parameter int LOCK_COUNT = 64,
   parameter int LOL_WINDOW = 64,
   parameter int LOL_THRESH = 8,
   parameter int CNT_W      = 32
) (
   input  logic             Clk,
   input  logic             ARst,
   input  logic             Enable,
   input  logic             Load,
   input  logic [31:0]      Seed,
   input  logic             RxBit,
   input  logic             ClrCnt,
   output logic             Locked,
   output logic [CNT_W-1:0] ErrCount,
   output logic [CNT_W-1:0] BitCount
);

   localparam int WB_W = $clog2(LOL_WINDOW);
   localparam int WE_W = $clog2(LOL_THRESH + 1);

   localparam logic [7:0]       RUN_ONE   = 8'd1;
   localparam logic [7:0]       RUN_LOCK  = 8'(LOCK_COUNT);
   localparam logic [WB_W-1:0]  WB_ONE    = WB_W'(1);
   localparam logic [WB_W-1:0]  WB_LAST   = WB_W'(LOL_WINDOW - 1);
   localparam logic [WE_W-1:0]  WE_ONE    = WE_W'(1);
   localparam logic [WE_W-1:0]  WE_THRESH = WE_W'(LOL_THRESH);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   chk_state_e      state;
   logic [31:0]     s;
   logic [7:0]      run_cnt;
   logic [WB_W-1:0] win_bits;
   logic [WE_W-1:0] win_errs;

   logic            match;
   logic [31:0]     s_next;
   logic [7:0]      run_inc;
   logic [WE_W-1:0] win_errs_inc;
   logic            lol_hit;

   assign match        = (RxBit == s[0]);
   assign s_next       = lfsr32_step(s);
   assign run_inc      = run_cnt + RUN_ONE;
   assign win_errs_inc = win_errs + WE_ONE;
   assign lol_hit      = !match && (win_errs_inc == WE_THRESH);

   always_ff @(posedge Clk or posedge ARst) begin
      if (ARst) begin
         state    <= HUNT;
         s        <= LFSR32_RESET;
         run_cnt  <= '0;
         win_bits <= '0;
         win_errs <= '0;
         Locked   <= 1'b0;
         ErrCount <= '0;
         BitCount <= '0;
      end else if (Load) begin
         state    <= HUNT;
         s        <= Seed;
         run_cnt  <= '0;
         win_bits <= '0;
         win_errs <= '0;
         Locked   <= 1'b0;
         ErrCount <= '0;
         BitCount <= '0;
      end else if (Enable) begin
         if (state == HUNT) begin
            // A mismatch holds s, so the replica waits one bit for the stream.
            if (match) begin
               s <= s_next;
               if (run_inc == RUN_LOCK) begin
                  state    <= LOCKED;
                  Locked   <= 1'b1;
                  run_cnt  <= '0;
                  win_bits <= '0;
                  win_errs <= '0;
               end else begin
                  run_cnt <= run_inc;
               end
            end else begin
               run_cnt <= '0;
            end
         end else begin
            s        <= s_next;
            win_bits <= win_bits + WB_ONE;
            if (BitCount != '1) BitCount <= BitCount + CNT_ONE;
            if (!match && ErrCount != '1) ErrCount <= ErrCount + CNT_ONE;
            // The threshold test wins over the window wrap on the last bit.
            if (lol_hit) begin
               state    <= HUNT;
               Locked   <= 1'b0;
               run_cnt  <= '0;
               win_errs <= '0;
            end else if (win_bits == WB_LAST) begin
               win_errs <= '0;
            end else if (!match) begin
               win_errs <= win_errs_inc;
            end
         end
         if (ClrCnt) begin
            ErrCount <= '0;
            BitCount <= '0;
         end
      end
   end

endmodule

// File: tb/tb_lfsr32_checker.sv
// Self-checking bench for lfsr32_checker: a reference generator drives the
// serial stream, expected outputs go through a queue and are compared per bit.
module tb_lfsr32_checker;

   logic        Clk = 1'b0;
   logic        ARst;
   logic        Enable;
   logic        Load;
   logic [31:0] Seed;
   logic        RxBit;
   logic        ClrCnt;
   logic        Locked;
   logic [31:0] ErrCount;
   logic [31:0] BitCount;
   logic        s_locked;
   logic [3:0]  s_err;
   logic [3:0]  s_bit;

   logic [31:0] gen_s;
   logic [64:0] exp_q[$];
   logic [64:0] exp_v;
   logic [64:0] act_v;
   int          errors = 0;
   int          checks = 0;

   always #5 Clk = ~Clk;

   lfsr32_checker dut (
      .Clk(Clk), .ARst(ARst), .Enable(Enable), .Load(Load), .Seed(Seed),
      .RxBit(RxBit), .ClrCnt(ClrCnt), .Locked(Locked),
      .ErrCount(ErrCount), .BitCount(BitCount)
   );

   lfsr32_checker #(.LOL_WINDOW(64), .LOL_THRESH(64), .CNT_W(4)) dut_sat (
      .Clk(Clk), .ARst(ARst), .Enable(Enable), .Load(Load), .Seed(Seed),
      .RxBit(RxBit), .ClrCnt(ClrCnt), .Locked(s_locked),
      .ErrCount(s_err), .BitCount(s_bit)
   );

   // ---------------- reference generator ----------------
   function automatic logic [31:0] gen_step(input logic [31:0] st);
      logic [31:0] n;
      n     = {st[0], st[31:1]};
      n[21] = n[21] ^ st[0];
      n[1]  = n[1] ^ st[0];
      n[0]  = n[0] ^ st[0];
      return n;
   endfunction

   task automatic gen_next(output logic b);
      b     = gen_s[0];
      gen_s = gen_step(gen_s);
   endtask

   // ---------------- driver tasks ----------------
   task automatic cycle(input logic en, input logic rx, input logic clr);
      Enable = en;
      RxBit  = rx;
      ClrCnt = clr;
      @(posedge Clk);
      #1;
      Enable = 1'b0;
      ClrCnt = 1'b0;
   endtask

   task automatic do_load(input logic [31:0] seed);
      Seed   = seed;
      Load   = 1'b1;
      Enable = 1'b0;
      @(posedge Clk);
      #1;
      Load  = 1'b0;
      gen_s = seed;
   endtask

   task automatic lock_fresh(input logic [31:0] seed);
      logic b;
      do_load(seed);
      checks++;
      if (Locked !== 1'b0 || ErrCount !== 32'd0 || BitCount !== 32'd0) begin
         errors++;
         $display("FAIL load_clear: got locked=%b err=%0d bits=%0d want 0/0/0",
                  Locked, ErrCount, BitCount);
      end
      for (int i = 0; i < 64; i++) begin
         gen_next(b);
         cycle(1'b1, b, 1'b0);
      end
      checks++;
      if (Locked !== 1'b1) begin
         errors++;
         $display("FAIL lock_fresh: got locked=%b want 1", Locked);
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      ARst = 1'b1; Enable = 1'b0; Load = 1'b0; Seed = 32'h0;
      RxBit = 1'b0; ClrCnt = 1'b0;
      repeat (3) @(posedge Clk);
      #1;
      checks++;
      if ({Locked, ErrCount, BitCount} !== 65'd0) begin
         errors++;
         $display("FAIL reset_main: got %h want 0", {Locked, ErrCount, BitCount});
      end
      checks++;
      if ({s_locked, s_err, s_bit} !== 9'd0) begin
         errors++;
         $display("FAIL reset_sat: got %h want 0", {s_locked, s_err, s_bit});
      end
      ARst = 1'b0;
      @(posedge Clk);
      #1;
   endtask

   task automatic test_aligned_lock();
      logic        b;
      logic [31:0] eb;
      int          k;
      k = 0;
      do_load(32'h0000_0001);
      for (int i = 0; i < 400 && k < 120; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            eb = (k > 64) ? 32'(k - 64) : 32'd0;
            exp_q.push_back({(k >= 64), 32'd0, eb});
            cycle(1'b0, ~gen_s[0], 1'b0);
         end else begin
            gen_next(b);
            k++;
            eb = (k > 64) ? 32'(k - 64) : 32'd0;
            exp_q.push_back({(k >= 64), 32'd0, eb});
            cycle(1'b1, b, 1'b0);
         end
         exp_v = exp_q.pop_front();
         act_v = {Locked, ErrCount, BitCount};
         checks++;
         if (act_v !== exp_v) begin
            errors++;
            $display("FAIL aligned bit=%0d: got %h want %h", k, act_v, exp_v);
         end
      end
   endtask

   task automatic test_delayed_stream();
      logic b;
      do_load(32'h0000_0001);
      // 5 idle-high bits, then the stream; no lock is possible in these 64 cycles
      for (int i = 0; i < 64; i++) begin
         if (i < 5) b = 1'b1;
         else gen_next(b);
         cycle(1'b1, b, 1'b0);
         checks++;
         if (Locked !== 1'b0) begin
            errors++;
            $display("FAIL delayed_early_lock cyc=%0d: got locked=%b want 0", i, Locked);
         end
      end
      for (int i = 0; i < 150 && Locked !== 1'b1; i++) begin
         gen_next(b);
         cycle(1'b1, b, 1'b0);
      end
      checks++;
      if (Locked !== 1'b1) begin
         errors++;
         $display("FAIL delayed_lock_timeout: got locked=%b want 1", Locked);
      end
      for (int n = 1; n <= 1000; n++) begin
         gen_next(b);
         exp_q.push_back({1'b1, 32'd0, 32'(n)});
         cycle(1'b1, b, 1'b0);
         exp_v = exp_q.pop_front();
         act_v = {Locked, ErrCount, BitCount};
         checks++;
         if (act_v !== exp_v) begin
            errors++;
            $display("FAIL delayed_run bit=%0d: got %h want %h", n, act_v, exp_v);
         end
      end
   endtask

   task automatic test_isolated_errors();
      logic b;
      logic flip;
      int   e;
      e = 0;
      lock_fresh(32'hACE1_2345);
      for (int i = 0; i < 250; i++) begin
         gen_next(b);
         flip = (i == 10 || i == 90 || i == 170);
         if (flip) e++;
         exp_q.push_back({1'b1, 32'(e), 32'(i + 1)});
         cycle(1'b1, b ^ flip, 1'b0);
         exp_v = exp_q.pop_front();
         act_v = {Locked, ErrCount, BitCount};
         checks++;
         if (act_v !== exp_v) begin
            errors++;
            $display("FAIL isolated bit=%0d: got %h want %h", i, act_v, exp_v);
         end
      end
   endtask

   task automatic test_burst_lol();
      logic        b;
      logic        flip;
      logic        el;
      logic [31:0] eb;
      int          e;
      e = 0;
      lock_fresh(32'h1234_5678);
      for (int i = 0; i < 110; i++) begin
         gen_next(b);
         flip = (i >= 20 && i < 28);
         if (flip) e++;
         el = (i < 27) || (i >= 91);
         if (i <= 27) eb = 32'(i + 1);
         else if (i <= 91) eb = 32'd28;
         else eb = 32'(28 + i - 91);
         exp_q.push_back({el, 32'(e), eb});
         cycle(1'b1, b ^ flip, 1'b0);
         exp_v = exp_q.pop_front();
         act_v = {Locked, ErrCount, BitCount};
         checks++;
         if (act_v !== exp_v) begin
            errors++;
            $display("FAIL burst bit=%0d: got %h want %h", i, act_v, exp_v);
         end
      end
   endtask

   task automatic test_clr_with_error();
      logic b;
      lock_fresh(32'h0F0F_1234);
      for (int i = 0; i < 8; i++) begin
         gen_next(b);
         if (i < 5)       exp_q.push_back({1'b1, 32'd0, 32'(i + 1)});
         else if (i == 5) exp_q.push_back({1'b1, 32'd0, 32'd0});
         else if (i == 6) exp_q.push_back({1'b1, 32'd0, 32'd1});
         else             exp_q.push_back({1'b1, 32'd1, 32'd2});
         cycle(1'b1, b ^ (i == 5 || i == 7), (i == 5));
         exp_v = exp_q.pop_front();
         act_v = {Locked, ErrCount, BitCount};
         checks++;
         if (act_v !== exp_v) begin
            errors++;
            $display("FAIL clr_cnt step=%0d: got %h want %h", i, act_v, exp_v);
         end
      end
   endtask

   task automatic test_saturation();
      logic       b;
      logic [3:0] ee;
      logic [3:0] eb;
      lock_fresh(32'h5555_AAAA);
      for (int i = 0; i < 50; i++) begin
         gen_next(b);
         ee = (i < 15) ? 4'(i + 1) : 4'hF;
         eb = (i < 15) ? 4'(i + 1) : 4'hF;
         if (i >= 20) ee = 4'hF;
         exp_q.push_back({1'b1, 28'd0, ee, 28'd0, eb});
         cycle(1'b1, b ^ (i < 20), 1'b0);
         exp_v = exp_q.pop_front();
         act_v = {s_locked, 28'd0, s_err, 28'd0, s_bit};
         checks++;
         if (act_v !== exp_v) begin
            errors++;
            $display("FAIL saturate bit=%0d: got %h want %h", i, act_v, exp_v);
         end
      end
   endtask

   task automatic test_arst_midlock();
      logic b;
      lock_fresh(32'h0000_0001);
      for (int i = 0; i < 10; i++) begin
         gen_next(b);
         cycle(1'b1, b ^ (i == 4), 1'b0);
      end
      checks++;
      if ({Locked, ErrCount, BitCount} !== {1'b1, 32'd1, 32'd10}) begin
         errors++;
         $display("FAIL pre_arst: got %h want %h", {Locked, ErrCount, BitCount},
                  {1'b1, 32'd1, 32'd10});
      end
      #2;
      ARst = 1'b1;
      #1;
      checks++;
      if ({Locked, ErrCount, BitCount} !== 65'd0) begin
         errors++;
         $display("FAIL arst_async: got %h want 0", {Locked, ErrCount, BitCount});
      end
      @(posedge Clk);
      #1;
      ARst = 1'b0;
      // Reset state equals seed 1, so a seed-1 stream locks without Load.
      gen_s = 32'h0000_0001;
      for (int k = 1; k <= 70; k++) begin
         gen_next(b);
         exp_q.push_back({(k >= 64), 32'd0, (k > 64) ? 32'(k - 64) : 32'd0});
         cycle(1'b1, b, 1'b0);
         exp_v = exp_q.pop_front();
         act_v = {Locked, ErrCount, BitCount};
         checks++;
         if (act_v !== exp_v) begin
            errors++;
            $display("FAIL post_arst bit=%0d: got %h want %h", k, act_v, exp_v);
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_aligned_lock();
      test_delayed_stream();
      test_isolated_errors();
      test_burst_lol();
      test_clr_with_error();
      test_saturation();
      test_arst_midlock();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
